memory_bridge: RTL
==================

MEMORY_BRIDGE -- requirements
Module: memory_bridge

Interface
REQ-001 Parameter RAM_WORDS, default 4096, number of 32-bit words in the attached RAM (power of two).
REQ-002 Parameter UART_BASE, default 32'h1000_0000, base address of the UART MMIO window.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memory_enable  input  1  core request strobe; honoured only while memory_ready=1.
REQ-006 memory_command  input  1  0=read, 1=write.
REQ-007 memory_address  input  32  byte address of the request.
REQ-008 memory_write_data  input  32  write data, already lane-aligned.
REQ-009 memory_write_mask  input  4  byte-lane enables for writes.
REQ-010 memory_ready  output  1  bridge can accept a request this cycle.
REQ-011 memory_valid  output  1  one-cycle completion pulse.
REQ-012 memory_read_data  output  32  read result, meaningful only with memory_valid.
REQ-013 memory_fault  output  1  access fault, qualifies memory_valid.
REQ-014 ram_enable / ram_write_enable  output  1 / 4  RAM access strobe / byte write enables.
REQ-015 ram_address  output  log2(RAM_WORDS)  RAM word address.
REQ-016 ram_write_data / ram_read_data  output / input  32  RAM data; read data valid one cycle after ram_enable.
REQ-017 uart_tx_data  output  8  byte to transmit.
REQ-018 uart_tx_valid / uart_tx_ready  output / input  1  valid/ready handshake to the UART transmitter.

Function
REQ-019 The address map SHALL be: RAM at 0 to RAM_WORDS*4-1; UART_DATA at UART_BASE (write only, bits 7:0); UART_STATUS at UART_BASE+4 (read only, bit0 = uart_tx_ready); all other addresses unmapped.
REQ-020 The FSM SHALL have states IDLE, RAM_ACCESS, UART_WAIT, RESPOND.
REQ-021 In IDLE, memory_ready=1; in all other states memory_ready=0.
REQ-022 A request is accepted when memory_enable=1 and memory_ready=1; command, address, data and mask SHALL be captured in that cycle (T).
REQ-023 A RAM request SHALL move to RAM_ACCESS at T+1, drive ram_enable=1 with ram_address=address[log2(RAM_WORDS)+1:2], and drive ram_write_enable=mask for writes (0 for reads).
REQ-024 From RAM_ACCESS, the FSM SHALL enter RESPOND at T+2 and pulse memory_valid, with memory_read_data=ram_read_data for reads and 0 for writes.
REQ-025 A UART_DATA write SHALL enter UART_WAIT and hold uart_tx_valid=1 with uart_tx_data=data[7:0] until uart_tx_ready=1; the FSM SHALL then enter RESPOND in the next cycle.
REQ-026 A UART_STATUS read SHALL enter RESPOND at T+1 with memory_read_data={31'b0, uart_tx_ready sampled at T}.
REQ-027 An unmapped address, a read of UART_DATA, or a write of UART_STATUS SHALL enter RESPOND at T+1 with memory_fault=1 and memory_read_data=0, and SHALL have no RAM or UART side effect.
REQ-028 RESPOND SHALL last exactly one cycle and then return to IDLE, so memory_ready is 1 again one cycle after memory_valid.
REQ-029 memory_enable outside IDLE SHALL be ignored; it is neither queued nor faulted.
REQ-030 memory_valid, memory_fault, ram_enable, ram_write_enable and uart_tx_valid SHALL be 0 in every state and cycle not named above.
REQ-031 memory_read_data SHALL be 0 whenever memory_valid=0.
REQ-032 A write with memory_write_mask=0 SHALL complete normally with no bytes changed.

Reset
REQ-033 Reset SHALL force IDLE and clear the captured request, including mid-operation.
REQ-034 In the cycle after reset: memory_ready=1, memory_valid=0, memory_fault=0, memory_read_data=0, ram_enable=0, ram_write_enable=0, uart_tx_valid=0, uart_tx_data=0.
REQ-035 A UART transfer pending at reset SHALL be abandoned, with uart_tx_valid dropping without a handshake.

Structure
REQ-036 A shared package SHALL hold the state enum, the memory_command encodings (READ=0, WRITE=1) and the UART register offsets.
REQ-037 Region decode SHALL be a single combinational sub-module, address_decoder, with outputs is_ram, is_uart_data, is_uart_status and is_unmapped.

Verification
REQ-038 RAM write: addr 0x10, data 0xDEADBEEF, mask 4'b1111 -> ram_write_enable=4'hF and ram_address=4 at T+1; memory_valid at T+2 with fault=0.
REQ-039 RAM read back: addr 0x10 -> memory_valid at T+2 with data 0xDEADBEEF; memory_ready=1 at T+3.
REQ-040 UART backpressure: write 0x41 to UART_BASE with uart_tx_ready low for 5 cycles -> uart_tx_valid held 5 cycles, one handshake, memory_valid on the cycle after the handshake.
REQ-041 Fault: read 0x2000_0000 -> memory_valid and memory_fault at T+1, data 0, no ram_enable.
REQ-042 Reset in UART_WAIT -> uart_tx_valid=0 and memory_ready=1 the next cycle; no memory_valid is issued.
REQ-043 memory_enable held high during RAM_ACCESS -> exactly one request is accepted.

Source files
------------

// File: rtl/memory_bridge_pkg.sv
// Shared types and constants for the core-to-RAM/UART memory bridge.
package memory_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRamAccess,
    StUartWait,
    StRespond
  } bridge_state_e;

  typedef enum logic {
    CmdRead  = 1'b0,
    CmdWrite = 1'b1
  } mem_cmd_e;

  localparam logic [31:0] UartDataOffset   = 32'h0000_0000;
  localparam logic [31:0] UartStatusOffset = 32'h0000_0004;

endpackage

// File: rtl/memory_bridge_if.sv
// Core-side request/response bus of the memory bridge.
interface memory_bridge_if;
  logic        memory_enable;
  logic        memory_command;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_write_mask;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] memory_read_data;
  logic        memory_fault;

  modport master (
    output memory_enable, memory_command, memory_address, memory_write_data, memory_write_mask,
    input  memory_ready, memory_valid, memory_read_data, memory_fault
  );

  modport slave (
    input  memory_enable, memory_command, memory_address, memory_write_data, memory_write_mask,
    output memory_ready, memory_valid, memory_read_data, memory_fault
  );
endinterface

// File: rtl/address_decoder.sv
// Combinational region decode of a core byte address into RAM, UART data, UART status or hole.
module address_decoder
  import memory_bridge_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] UART_BASE = 32'h1000_0000
) (
  input  logic [31:0] address,
  output logic        is_ram,
  output logic        is_uart_data,
  output logic        is_uart_status,
  output logic        is_unmapped
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);

  always_comb begin
    is_ram         = (address[31:RamAw+2] == '0);
    is_uart_data   = (address == (UART_BASE + UartDataOffset));
    is_uart_status = (address == (UART_BASE + UartStatusOffset));
    is_unmapped    = !(is_ram || is_uart_data || is_uart_status);
  end

endmodule

// File: rtl/memory_bridge.sv
// Single-outstanding bridge from the core memory bus to a synchronous RAM and a UART transmitter.
module memory_bridge
  import memory_bridge_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] UART_BASE = 32'h1000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  memory_bridge_if.slave               mem,
  output logic                         ram_enable,
  output logic [3:0]                   ram_write_enable,
  output logic [$clog2(RAM_WORDS)-1:0] ram_address,
  output logic [31:0]                  ram_write_data,
  input  logic [31:0]                  ram_read_data,
  output logic [7:0]                   uart_tx_data,
  output logic                         uart_tx_valid,
  input  logic                         uart_tx_ready
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);

  bridge_state_e    state_q, state_d;
  mem_cmd_e         cmd_q;
  logic [RamAw-1:0] word_addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       mask_q;
  logic             is_ram_q;
  logic             fault_q;
  logic [31:0]      resp_data_q;

  logic is_ram, is_uart_data, is_uart_status, is_unmapped;
  logic accept;
  logic req_write;

  address_decoder #(
    .RAM_WORDS(RAM_WORDS),
    .UART_BASE(UART_BASE)
  ) u_address_decoder (
    .address       (mem.memory_address),
    .is_ram        (is_ram),
    .is_uart_data  (is_uart_data),
    .is_uart_status(is_uart_status),
    .is_unmapped   (is_unmapped)
  );

  assign accept    = (state_q == StIdle) && mem.memory_enable;
  assign req_write = (mem_cmd_e'(mem.memory_command) == CmdWrite);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= CmdRead;
      word_addr_q <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      is_ram_q    <= 1'b0;
      fault_q     <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q       <= mem_cmd_e'(mem.memory_command);
        word_addr_q <= mem.memory_address[RamAw+1:2];
        wdata_q     <= mem.memory_write_data;
        mask_q      <= mem.memory_write_mask;
        is_ram_q    <= is_ram;
        // Direction mismatches on the UART registers fault just like holes in the map.
        fault_q     <= is_unmapped || (is_uart_data && !req_write) ||
                       (is_uart_status && req_write);
        resp_data_q <= (is_uart_status && !req_write) ? {31'b0, uart_tx_ready} : 32'b0;
      end
    end
  end

  assign ram_address    = word_addr_q;
  assign ram_write_data = wdata_q;
  assign uart_tx_data   = wdata_q[7:0];

  always_comb begin
    state_d              = state_q;
    mem.memory_ready     = 1'b0;
    mem.memory_valid     = 1'b0;
    mem.memory_fault     = 1'b0;
    mem.memory_read_data = 32'b0;
    ram_enable           = 1'b0;
    ram_write_enable     = 4'b0;
    uart_tx_valid        = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem.memory_ready = 1'b1;
        if (mem.memory_enable) begin
          if (is_ram) begin
            state_d = StRamAccess;
          end else if (is_uart_data && req_write) begin
            state_d = StUartWait;
          end else begin
            state_d = StRespond;
          end
        end
      end
      StRamAccess: begin
        ram_enable       = 1'b1;
        ram_write_enable = (cmd_q == CmdWrite) ? mask_q : 4'b0;
        state_d          = StRespond;
      end
      StUartWait: begin
        uart_tx_valid = 1'b1;
        if (uart_tx_ready) begin
          state_d = StRespond;
        end
      end
      StRespond: begin
        mem.memory_valid = 1'b1;
        mem.memory_fault = fault_q;
        // RAM read data arrives one cycle after ram_enable, i.e. in this state.
        mem.memory_read_data = (is_ram_q && cmd_q == CmdRead) ? ram_read_data : resp_data_q;
        state_d              = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
